// File: rtl/sb_pack_pkg.sv
// sb_pack_pkg: shared types and helpers for the switchboard packet assembler.
//   SB_IW / SB_DW : default word and packet widths
//   calc_nw()     : words per packet
//   sb_pkt_t      : one buffered packet {data, dest, last}
package sb_pack_pkg;

    localparam int SB_IW = 32;
    localparam int SB_DW = 416;

    function automatic int calc_nw(input int dw, input int iw);
        return dw / iw;
    endfunction

    typedef struct packed {
        logic [SB_DW-1:0] data;
        logic [31:0]      dest;
        logic             last;
    } sb_pkt_t;

endpackage

// File: rtl/sb_pack_tx_if.sv
// sb_pack_tx_if: word input stream, destination config and packet output
// stream of the assembler.
//   slave  : the assembler side (consumes words, produces packets)
//   master : the surrounding logic / bench side
interface sb_pack_tx_if #(
    parameter int IW = 32,
    parameter int DW = 416
);
    logic [IW-1:0] in_data;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   cfg_dest;
    logic [DW-1:0] data;
    logic [31:0]   dest;
    logic          last;
    logic          valid;
    logic          ready;
    logic [31:0]   pkt_count;

    modport slave (
        input  in_data, in_last, in_valid, cfg_dest, ready,
        output in_ready, data, dest, last, valid, pkt_count
    );

    modport master (
        output in_data, in_last, in_valid, cfg_dest, ready,
        input  in_ready, data, dest, last, valid, pkt_count
    );
endinterface

// File: rtl/sb_pack_obuf.sv
// sb_pack_obuf: 2-entry registered FIFO of sb_pkt_t.
//   clk, nreset : clock, async active-low reset
//   push, push_pkt : enqueue (caller guarantees room)
//   pop         : dequeue head (caller guarantees non-empty)
//   head        : head entry, occ / occ_next : current and next occupancy
module sb_pack_obuf
    import sb_pack_pkg::*;
(
    input  logic    clk,
    input  logic    nreset,
    input  logic    push,
    input  sb_pkt_t push_pkt,
    input  logic    pop,
    output sb_pkt_t head,
    output logic [1:0] occ,
    output logic [1:0] occ_next
);
    sb_pkt_t    ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0] occ_q, occ_d;

    // ent0 is always the head; ent1 only holds data when occ == 2.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
        case (occ_q)
            2'd0: if (push) ent0_d = push_pkt;
            2'd1: begin
                if (push && pop) ent0_d = push_pkt;
                else if (push)   ent1_d = push_pkt;
            end
            default: if (pop) begin
                ent0_d = ent1_q;
                if (push) ent1_d = push_pkt;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign head     = ent0_q;
    assign occ      = occ_q;
    assign occ_next = occ_d;
endmodule

// File: rtl/sb_pack_tx.sv
// sb_pack_tx: packs IW-bit words into DW-bit switchboard packets tagged with
// a destination and a last flag, buffered through a 2-entry output FIFO.
//   clk, nreset : clock, async active-low reset
//   bus (slave) : in_data/in_last/in_valid/in_ready word stream, cfg_dest,
//                 data/dest/last/valid/ready packet stream, pkt_count
module sb_pack_tx
    import sb_pack_pkg::*;
#(
    parameter int IW = SB_IW,
    parameter int DW = SB_DW
) (
    input logic          clk,
    input logic          nreset,
    sb_pack_tx_if.slave  bus
);
    localparam int NW = calc_nw(DW, IW);
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NW - 1);

    if (DW % IW != 0) begin : g_bad_dw
        $error("sb_pack_tx: DW must be a multiple of IW");
    end
    if (DW != SB_DW) begin : g_bad_pkt
        $error("sb_pack_tx: DW must match sb_pkt_t data width");
    end

    logic [DW-1:0] acc_q, acc_d, acc_ins;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   acc_dest_q, acc_dest_d;
    logic          in_ready_q, in_ready_d;
    logic [31:0]   pkt_count_q, pkt_count_d;

    logic       accept, close, pop;
    sb_pkt_t    push_pkt, head;
    logic [1:0] occ, occ_next;

    assign accept = bus.in_valid && in_ready_q;
    assign close  = accept && ((cnt_q == CNT_LAST) || bus.in_last);
    assign pop    = (occ != 2'd0) && bus.ready;

    always_comb begin
        acc_ins = acc_q;
        acc_ins[cnt_q*IW +: IW] = bus.in_data;
    end

    // On a first-word close acc_dest_q is still stale, so forward cfg_dest.
    always_comb begin
        push_pkt.data = acc_ins;
        push_pkt.dest = (cnt_q == '0) ? bus.cfg_dest : acc_dest_q;
        push_pkt.last = bus.in_last;
    end

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        acc_dest_d  = acc_dest_q;
        if (accept) begin
            if (cnt_q == '0) acc_dest_d = bus.cfg_dest;
            if (close) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = acc_ins;
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Only take a word when any close it might cause still fits.
        in_ready_d  = (occ_next < 2'd2);
        pkt_count_d = pkt_count_q + 32'(pop);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_dest_q  <= '0;
            in_ready_q  <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            acc_dest_q  <= acc_dest_d;
            in_ready_q  <= in_ready_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    sb_pack_obuf u_obuf (
        .clk      (clk),
        .nreset   (nreset),
        .push     (close),
        .push_pkt (push_pkt),
        .pop      (pop),
        .head     (head),
        .occ      (occ),
        .occ_next (occ_next)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.valid     = (occ != 2'd0);
    assign bus.data      = head.data;
    assign bus.dest      = head.dest;
    assign bus.last      = head.last;
    assign bus.pkt_count = pkt_count_q;
endmodule
